seq_game_engine: RTL
====================

# seq_game_engine

Parametrised sequence-memory game core: plays a stored note sequence of growing length on the piezo/LED outputs, then checks the player's answers note by note. It sits between the button/keypad input decoder and the piezo tone generator and LED driver. It is the generalised successor of the fixed 4-bit/8-note game core, with a configurable note width, sequence depth and tick rate, and an optional answer timeout.

## Interface
- NOTE_W, 4: bits per note.
- SEQ_LEN, 8: notes stored; maximum level.
- START_LEN, 3: level at game start; legal range 1..SEQ_LEN.
- TICK_DIV, 5000000: clk cycles per tick.
- NOTE_TICKS, 2: ticks a note sounds during playback.
- GAP_TICKS, 1: silent ticks after each played note.
- TIMEOUT_TICKS, 10: answer timeout; used only with TIMEOUT_EN.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- seq_load  in  1  pulse: load seq_data.
- seq_data  in  NOTE_W*SEQ_LEN  note i at [i*NOTE_W +: NOTE_W].
- start  in  1  pulse: begin game.
- ans_valid  in  1  one-cycle answer strobe.
- ans_note  in  NOTE_W  player's note.
- note_out  out  NOTE_W  piezo note; 0 means silent.
- led_out  out  NOTE_W  LED pattern.
- state_out  out  3  FSM state code.
- level  out  $clog2(SEQ_LEN+1)  current sequence length.
- score  out  8  completed rounds, saturates at 255.
- miss_count  out  8  misses, saturates at 255.
- miss  out  1  one-cycle pulse on a wrong answer or timeout.
- round_ok  out  1  one-cycle pulse when a level is cleared.
- win  out  1  one-cycle pulse when level SEQ_LEN is cleared.

## Operation
- States and codes: IDLE=0, PLAY_ON=1, PLAY_GAP=2, LISTEN=3, DONE=4.
- seq_load is accepted only in IDLE or DONE and is ignored in all other states.
- start is accepted only in IDLE or DONE. It sets level=START_LEN, idx=0, score=0, miss_count=0, then goes to PLAY_ON.
- seq_load and start in the same cycle: the register loads and the game starts; playback uses the new data.
- PLAY_ON: note_out = led_out = note[idx]. After NOTE_TICKS ticks, go to PLAY_GAP.
- PLAY_GAP: note_out = led_out = 0. After GAP_TICKS ticks:
  - if idx == level-1: idx=0, go to LISTEN;
  - otherwise idx+1, go to PLAY_ON.
- LISTEN: note_out = 0; led_out echoes the last accepted ans_note. On ans_valid:
  - mismatch with note[idx]: pulse miss, miss_count+1, idx=0, replay the same level (PLAY_ON);
  - match, idx < level-1: idx+1;
  - match, idx == level-1, level < SEQ_LEN: pulse round_ok, score+1, level+1, idx=0, go to PLAY_ON;
  - match, idx == level-1, level == SEQ_LEN: pulse round_ok and win, score+1, go to DONE.
- ans_valid outside LISTEN is ignored.
- DONE: outputs silent; holds level and score until the next start.
- Comparison is a full NOTE_W-bit equality. A note value of 0 is legal and plays as silence.

## Timing
- Reset values: all outputs 0, state IDLE, level 0, register 0, idx 0, tick counter 0.
- Tick counter counts 0..TICK_DIV-1 and pulses at TICK_DIV-1. It clears on every state transition, so each phase lasts exactly N*TICK_DIV cycles.
- start accepted at cycle t: state_out=1 and note_out=note[0] at t+1.
- ans_valid at cycle t: miss, round_ok and win are registered pulses at t+1, together with the state change.
- A counter increment and a new level are visible in the same cycle as their pulse.
- Reset asserted mid-game aborts immediately to the reset values, including a pulse in flight.

## Configuration
- TIMEOUT_EN defined: in LISTEN, if TIMEOUT_TICKS ticks pass with no ans_valid, this counts as a miss (miss pulse, miss_count+1, replay the same level).
  - The timeout counter clears on entry to LISTEN and on every accepted answer.
  - If ans_valid arrives in the same cycle as the timeout, the answer takes priority.
- TIMEOUT_EN undefined: LISTEN waits indefinitely, and no timeout logic is synthesised.

## Test plan
- Playback timing:
  - Setup: NOTE_W=4, SEQ_LEN=8, START_LEN=3, TICK_DIV=4. Load 0x87654321, then start.
  - Required: note_out shows 1, 2, 3, each for 8 cycles followed by 4 silent cycles, then state_out=3.
- Correct round:
  - Stimulus: in LISTEN, answer 1, 2, 3.
  - Required: round_ok pulses 1 cycle after the 3rd answer; level=4, score=1; playback replays 1, 2, 3, 4.
- Wrong answer:
  - Stimulus: at level 3, answer 1 then 5.
  - Required: miss pulse, miss_count=1, level stays 3, replay starts at note 1.
- Full game:
  - Stimulus: clear all levels 3..8 correctly.
  - Required: win pulses exactly once, state_out=4, score=6. A subsequent seq_load of 0x11111111 is accepted; seq_load during play is ignored.
- Asynchronous reset:
  - Stimulus: assert reset mid-PLAY_ON while ans_valid and start are toggling.
  - Required: all outputs are 0 immediately; no pulses while reset is held.
- Timeout (TIMEOUT_EN, TIMEOUT_TICKS=10, TICK_DIV=4):
  - Stimulus: give no answer in LISTEN.
  - Required: miss pulses 40 cycles after LISTEN entry. An answer in the 40th cycle suppresses the timeout.

Source files
------------

// File: rtl/seq_game_engine.sv
// Sequence-memory game core: plays a growing note sequence, then checks the player's answers.
// Optional answer timeout in LISTEN is built only when TIMEOUT_EN is defined.
module seq_game_engine #(
    parameter int NOTE_W        = 4,
    parameter int SEQ_LEN       = 8,
    parameter int START_LEN     = 3,
    parameter int TICK_DIV      = 5000000,
    parameter int NOTE_TICKS    = 2,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         seq_load,
    input  logic [NOTE_W*SEQ_LEN-1:0]    seq_data,
    input  logic                         start,
    input  logic                         ans_valid,
    input  logic [NOTE_W-1:0]            ans_note,
    output logic [NOTE_W-1:0]            note_out,
    output logic [NOTE_W-1:0]            led_out,
    output logic [2:0]                   state_out,
    output logic [$clog2(SEQ_LEN+1)-1:0] level,
    output logic [7:0]                   score,
    output logic [7:0]                   miss_count,
    output logic                         miss,
    output logic                         round_ok,
    output logic                         win
);

    localparam int LW        = $clog2(SEQ_LEN + 1);
    localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHASE_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [LW-1:0] MAX_LEVEL   = LW'(SEQ_LEN);
    localparam logic [LW-1:0] FIRST_LEVEL = LW'(START_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY_ON  = 3'd1,
        PLAY_GAP = 3'd2,
        LISTEN   = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                      state, state_next;
    logic [NOTE_W*SEQ_LEN-1:0]   seq_reg, seq_next;
    logic [LW-1:0]               level_next;
    logic [LW-1:0]               idx, idx_next;
    logic [7:0]                  score_next, miss_count_next;
    logic [NOTE_W-1:0]           last_ans, last_ans_next;
    logic                        miss_next, round_ok_next, win_next;
    logic                        answered;
    logic [TW-1:0]               tick_cnt;
    logic [PW-1:0]               phase_cnt;
    logic                        tick;
    logic                        cnt_clear;
    logic                        last_idx;
    logic [NOTE_W-1:0]           cur_note;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cur_note  = seq_reg[idx*NOTE_W +: NOTE_W];
    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign last_idx  = (idx == level - LW'(1));
    // Every phase is timed from zero, so both counters restart on any state change or accepted answer.
    assign cnt_clear = (state_next != state) || answered;

`ifdef TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);

    logic [TOW-1:0] to_cnt;
    logic           timeout;

    assign timeout = (state == LISTEN) && tick && (to_cnt == TOW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (cnt_clear) begin
            to_cnt <= '0;
        end else if (tick) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_next      = state;
        seq_next        = seq_reg;
        level_next      = level;
        idx_next        = idx;
        score_next      = score;
        miss_count_next = miss_count;
        last_ans_next   = last_ans;
        miss_next       = 1'b0;
        round_ok_next   = 1'b0;
        win_next        = 1'b0;
        answered        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (seq_load) begin
                    seq_next = seq_data;
                end
                if (start) begin
                    state_next      = PLAY_ON;
                    level_next      = FIRST_LEVEL;
                    idx_next        = '0;
                    score_next      = 8'd0;
                    miss_count_next = 8'd0;
                end
            end
            PLAY_ON: begin
                if (tick && phase_cnt == PW'(NOTE_TICKS - 1)) begin
                    state_next = PLAY_GAP;
                end
            end
            PLAY_GAP: begin
                if (tick && phase_cnt == PW'(GAP_TICKS - 1)) begin
                    if (last_idx) begin
                        idx_next   = '0;
                        state_next = LISTEN;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = PLAY_ON;
                    end
                end
            end
            LISTEN: begin
                if (ans_valid) begin
                    answered      = 1'b1;
                    last_ans_next = ans_note;
                    if (ans_note != cur_note) begin
                        miss_next       = 1'b1;
                        miss_count_next = sat_inc(miss_count);
                        idx_next        = '0;
                        state_next      = PLAY_ON;
                    end else if (!last_idx) begin
                        idx_next = idx + 1'b1;
                    end else begin
                        round_ok_next = 1'b1;
                        score_next    = sat_inc(score);
                        if (level < MAX_LEVEL) begin
                            level_next = level + 1'b1;
                            idx_next   = '0;
                            state_next = PLAY_ON;
                        end else begin
                            win_next   = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
`ifdef TIMEOUT_EN
                else if (timeout) begin
                    miss_next       = 1'b1;
                    miss_count_next = sat_inc(miss_count);
                    idx_next        = '0;
                    state_next      = PLAY_ON;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            seq_reg    <= '0;
            level      <= '0;
            idx        <= '0;
            score      <= 8'd0;
            miss_count <= 8'd0;
            last_ans   <= '0;
            miss       <= 1'b0;
            round_ok   <= 1'b0;
            win        <= 1'b0;
        end else begin
            state      <= state_next;
            seq_reg    <= seq_next;
            level      <= level_next;
            idx        <= idx_next;
            score      <= score_next;
            miss_count <= miss_count_next;
            last_ans   <= last_ans_next;
            miss       <= miss_next;
            round_ok   <= round_ok_next;
            win        <= win_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            phase_cnt <= '0;
        end else if (cnt_clear) begin
            tick_cnt  <= '0;
            phase_cnt <= '0;
        end else if (tick) begin
            tick_cnt  <= '0;
            phase_cnt <= phase_cnt + 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end

    // LEDs mirror the piezo during playback and echo the player's last answer while listening.
    always_comb begin
        note_out = '0;
        led_out  = '0;
        case (state)
            PLAY_ON: begin
                note_out = cur_note;
                led_out  = cur_note;
            end
            LISTEN: begin
                led_out = last_ans;
            end
            default: begin
            end
        endcase
    end

    assign state_out = state;

endmodule
